// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N-LED status pattern generator (shift, bounce, fill, count, blink) advanced by a
// clock-enable prescaler or single-step. Define LED_PWM_EN to add a 4-bit PWM brightness gate.
module led_pattern_gen #(
  parameter int N_LED = 4,
  parameter int DIV   = 12500000,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             run,
  input  logic             step,
  input  logic [2:0]       mode,
  input  logic             dir,
  input  logic [3:0]       duty,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam logic [2:0]       M_SHIFT  = 3'd0;
  localparam logic [2:0]       M_BOUNCE = 3'd1;
  localparam logic [2:0]       M_FILL   = 3'd2;
  localparam logic [2:0]       M_COUNT  = 3'd3;
  localparam logic [2:0]       M_BLINK  = 3'd4;
  localparam logic [2:0]       M_RESET  = 3'b111;
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [N_LED-1:0] PAT_LSB  = N_LED'(1);
  localparam logic [N_LED-1:0] PAT_MSB  = PAT_LSB << (N_LED - 1);

  typedef enum logic {B_UP = 1'b0, B_DOWN = 1'b1} bounce_t;

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [N_LED-1:0] pattern, pat_nxt, pat_init, pat_adv, led_nxt;
  logic [2:0]       mode_q;
  bounce_t          bdir, bdir_nxt, bdir_adv;
  logic             wrap, adv, reload, tick_nxt;

  always_comb begin
    pat_init = '0;
    case (mode)
      M_SHIFT:  pat_init = dir ? PAT_MSB : PAT_LSB;
      M_BOUNCE: pat_init = PAT_LSB;
      default:  pat_init = '0;
    endcase
  end

  // Advance works on the loaded mode (mode_q); a differing mode input means a reload instead.
  always_comb begin
    pat_adv  = '0;
    bdir_adv = bdir;
    case (mode_q)
      M_SHIFT: begin
        if (dir) pat_adv = {pattern[0], pattern[N_LED-1:1]};
        else     pat_adv = {pattern[N_LED-2:0], pattern[N_LED-1]};
      end
      M_BOUNCE: begin
        if (bdir == B_UP) begin
          if (pattern[N_LED-1]) begin
            bdir_adv = B_DOWN;
            pat_adv  = pattern >> 1;
          end else begin
            pat_adv = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            bdir_adv = B_UP;
            pat_adv  = pattern << 1;
          end else begin
            pat_adv = pattern >> 1;
          end
        end
      end
      M_FILL: begin
        if (&pattern) pat_adv = '0;
        else if (dir) pat_adv = {1'b1, pattern[N_LED-1:1]};
        else          pat_adv = {pattern[N_LED-2:0], 1'b1};
      end
      M_COUNT: pat_adv = dir ? (pattern - PAT_LSB) : (pattern + PAT_LSB);
      M_BLINK: pat_adv = ~pattern;
      default: pat_adv = '0;
    endcase
  end

  // A reload swallows any coincident advance: no tick, counter and bounce direction restart.
  always_comb begin
    wrap     = run && (cnt == CNT_LAST);
    adv      = step || wrap;
    reload   = (mode != mode_q);
    cnt_nxt  = cnt;
    pat_nxt  = pattern;
    bdir_nxt = bdir;
    tick_nxt = 1'b0;
    if (reload) begin
      cnt_nxt  = '0;
      pat_nxt  = pat_init;
      bdir_nxt = B_UP;
    end else if (adv) begin
      cnt_nxt  = '0;
      pat_nxt  = pat_adv;
      bdir_nxt = bdir_adv;
      tick_nxt = 1'b1;
    end else if (run) begin
      cnt_nxt = cnt + CNT_ONE;
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;
  logic       pwm_en;

  assign pwm_en  = (duty == 4'hF) || (pwm_cnt < duty);
  assign led_nxt = pat_nxt & {N_LED{pwm_en}};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pwm_cnt <= 4'd0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end
`else
  logic unused_duty;

  assign unused_duty = ^duty;
  assign led_nxt     = pat_nxt;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt     <= '0;
      pattern <= '0;
      led     <= '0;
      tick    <= 1'b0;
      mode_q  <= M_RESET;
      bdir    <= B_UP;
    end else begin
      cnt     <= cnt_nxt;
      pattern <= pat_nxt;
      led     <= led_nxt;
      tick    <= tick_nxt;
      mode_q  <= mode;
      bdir    <= bdir_nxt;
    end
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator for board-level status and bring-up displays.
- Replaces the fixed 4-LED chaser, which used a derived divided clock. This block has a single clock domain: the prescaler produces a one-cycle clock-enable `tick`.
- Supports N LEDs, several display modes, a direction control, run/pause and single-step.
- Sits directly on the board LED pins or on a status bus.

Parameters:
- N_LED, 4, number of LED outputs; legal range 2..32.
- DIV, 12500000, clk cycles per pattern advance; legal range ≥2.
- DIV_W, 24, prescaler counter width; must satisfy 2^DIV_W > DIV.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- run  in  1  1 = prescaler counts and the pattern advances on tick; 0 = pause, counter holds.
- step  in  1  one-clk pulse that forces a single advance. Synchronous to clk.
- mode  in  3  0 SHIFT, 1 BOUNCE, 2 FILL, 3 COUNT, 4 BLINK, 5–7 OFF.
- dir  in  1  0 = toward MSB / count up; 1 = toward LSB / count down.
- duty  in  4  brightness control; used only with LED_PWM_EN.
- led  out  N_LED  registered LED drive, active-high.
- tick  out  1  one-clk pulse on every pattern advance, whether caused by the prescaler or by step.

Behaviour:
- Reset (nrst=0, async):
  - prescaler count = 0, pattern = 0, led = 0, tick = 0.
  - mode_q = 3'b111, bounce direction = up.
- Prescaler:
  - When run=1, the counter increments 0..DIV-1.
  - At DIV-1 it wraps to 0 and generates an advance.
  - When run=0, it holds its value.
- Step:
  - step=1 generates an advance regardless of run and clears the counter to 0.
  - If step and a prescaler wrap occur in the same cycle, only one advance happens.
- Advance (adv):
  - The pattern updates on the clk edge following the adv condition.
  - tick is registered and high for that same single cycle.
  - Latency from the wrap or step cycle to the led change is 1 clk.
- Mode change (mode != mode_q):
  - The next edge loads the mode's initial pattern and sets mode_q = mode.
  - The counter clears to 0, bounce direction resets to up, and tick stays 0.
  - A reload takes priority over a simultaneous adv, which is discarded.
  - Because mode_q resets to 3'b111, the first cycle after reset loads the initial pattern of the current mode (unless mode is OFF).
- Initial patterns:
  - SHIFT: 0..01 if dir=0, 10..0 if dir=1.
  - BOUNCE: 0..01.
  - FILL, COUNT, BLINK, OFF: all zeros.
- Per-mode advance:
  - SHIFT: rotate by one position (left if dir=0, right if dir=1); one-hot wraps end to end. A dir change takes effect at the next adv without reloading.
  - BOUNCE: dir is ignored. Going up: if the MSB is set, switch to down and shift right, otherwise shift left. Going down is the mirror at the LSB. Sequence for N=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - FILL, dir=0: p = {p[N-2:0], 1}; once all ones, the next adv clears to 0. dir=1 is the mirror, filling from the MSB.
  - COUNT: p ± 1 modulo 2^N_LED (up if dir=0, down if dir=1); wraps with no flag.
  - BLINK: p = ~p (all LEDs toggle together).
  - OFF: pattern held at 0; the prescaler and tick still run.
- Output: led = pattern, registered, with no combinational path from the inputs.
- Reset mid-operation: all state returns immediately (asynchronously) to the reset values above.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - A 4-bit free-running PWM counter increments every clk; it resets to 0.
  - led[i] = pattern[i] AND en.
  - en = 1 when duty==15, otherwise en = (pwm_cnt < duty).
  - duty=0 gives LEDs dark; duty=15 gives full on. duty is sampled every clk, with no glitch requirement.
  - led remains registered.
- Undefined: no PWM logic is built; duty is ignored and led = pattern.

Test Plan:
All tests use N_LED=4, DIV=4.
- Reset, mode=0, dir=0, run=1: led=0000 during reset. One clk after release, led=0001. Then 0010, 0100, 1000, 0001, spaced 4 clks apart, with a tick pulse coincident with each change.
- mode=1 for 8 advances: led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- mode=2, dir=0, then mode=3, dir=1: FILL gives 0000, 0001, 0011, 0111, 1111, 0000. COUNT down from 0000 gives 1111, 1110, 1101.
- run=0 with step pulsed 3 times, 10 clks apart, in SHIFT mode: exactly 3 advances and 3 ticks. The counter stays at 0 between steps. Asserting step in the same cycle as a prescaler wrap produces a single advance.
- Change mode from SHIFT (led=0100) to BLINK in the same cycle as a wrap: the next edge gives led=0000 with no tick. Subsequent advances give 1111, 0000.
- LED_PWM_EN defined, BLINK at 1111: duty=0 → led always 0000; duty=15 → always 1111; duty=4 → led high for exactly 4 of every 16 clks.
